// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte FIFOs,
// with optional CR->CRLF expansion and bit-7 masking on the transmitted byte.
module uart_tx_arbiter #(
    parameter int DEPTH = 16,
    parameter bit CRLF  = 1'b1,
    parameter bit MASK7 = 1'b1
) (
    input  logic       eclk,
    input  logic       ereset_n,
    input  logic       a_wr,
    input  logic [7:0] a_data,
    output logic       a_full,
    output logic       a_ovf,
    input  logic       b_wr,
    input  logic [7:0] b_data,
    output logic       b_full,
    output logic       b_ovf,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    input  logic       tx_flag,
    output logic       busy,
    output logic       grant
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

    state_t        state_q;
    logic [7:0]    a_mem_q [DEPTH];
    logic [7:0]    b_mem_q [DEPTH];
    logic [AW-1:0] a_wp_q, a_rp_q, b_wp_q, b_rp_q;
    logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic          a_ovf_q, b_ovf_q, grant_q, lf_pend_q, tx_wr_q;
    logic [7:0]    tx_data_q;

    logic          a_empty, b_empty, a_push, b_push, a_pop, b_pop;
    logic          pick_v, pick_b;
    logic [7:0]    head;

    assign a_full  = (a_cnt_q == CW'(DEPTH));
    assign b_full  = (b_cnt_q == CW'(DEPTH));
    assign a_empty = (a_cnt_q == '0);
    assign b_empty = (b_cnt_q == '0);
    assign a_ovf   = a_ovf_q;
    assign b_ovf   = b_ovf_q;
    assign tx_data = tx_data_q;
    assign tx_wr   = tx_wr_q;
    assign busy    = (state_q != IDLE);
    assign grant   = grant_q;

    // When both channels hold data, the one that did not win last time is served.
    always_comb begin
        a_push = a_wr && !a_full;
        b_push = b_wr && !b_full;
        pick_v = !a_empty || !b_empty;
        pick_b = (!a_empty && !b_empty) ? !grant_q : !b_empty;
        a_pop  = (state_q == IDLE) && tx_flag && pick_v && !pick_b;
        b_pop  = (state_q == IDLE) && tx_flag && pick_v && pick_b;
        head   = pick_b ? b_mem_q[b_rp_q] : a_mem_q[a_rp_q];

        a_cnt_d = a_cnt_q;
        if (a_push && !a_pop) begin
            a_cnt_d = a_cnt_q + CW'(1);
        end else if (!a_push && a_pop) begin
            a_cnt_d = a_cnt_q - CW'(1);
        end

        b_cnt_d = b_cnt_q;
        if (b_push && !b_pop) begin
            b_cnt_d = b_cnt_q + CW'(1);
        end else if (!b_push && b_pop) begin
            b_cnt_d = b_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge eclk) begin
        if (a_push) a_mem_q[a_wp_q] <= a_data;
        if (b_push) b_mem_q[b_wp_q] <= b_data;
    end

    always_ff @(posedge eclk) begin
        if (!ereset_n) begin
            state_q   <= IDLE;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b1;
            lf_pend_q <= 1'b0;
            a_wp_q    <= '0;
            a_rp_q    <= '0;
            b_wp_q    <= '0;
            b_rp_q    <= '0;
            a_cnt_q   <= '0;
            b_cnt_q   <= '0;
            a_ovf_q   <= 1'b0;
            b_ovf_q   <= 1'b0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            if (a_push) a_wp_q <= a_wp_q + AW'(1);
            if (b_push) b_wp_q <= b_wp_q + AW'(1);
            if (a_pop)  a_rp_q <= a_rp_q + AW'(1);
            if (b_pop)  b_rp_q <= b_rp_q + AW'(1);
            if (a_wr && a_full) a_ovf_q <= 1'b1;
            if (b_wr && b_full) b_ovf_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (a_pop || b_pop) begin
                        tx_data_q <= {head[7] & ~MASK7, head[6:0]};
                        grant_q   <= pick_b;
                        lf_pend_q <= CRLF && (head[6:0] == 7'h0D);
                        tx_wr_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_wr_q <= 1'b0;
                    state_q <= HOLD;
                end
                // The UART's ready flag lags the write strobe by a cycle.
                HOLD: state_q <= WAIT;
                WAIT: begin
                    if (tx_flag) begin
                        if (lf_pend_q) begin
                            tx_data_q <= 8'h0A;
                            lf_pend_q <= 1'b0;
                            tx_wr_q   <= 1'b1;
                            state_q   <= ISSUE;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (CRLF on/off) fed identical pushes,
// each with its own UART ready model; transmitted bytes are logged and checked.
module tb_uart_tx_arbiter;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       ereset_n = 1'b0;
    logic       a_wr = 1'b0, b_wr = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       flag_en = 1'b0;
    int         drop = 0;

    logic       a_full1, a_ovf1, b_full1, b_ovf1, tx_wr1, busy1, grant1, tx_flag1;
    logic [7:0] tx_data1;
    logic       a_full0, a_ovf0, b_full0, b_ovf0, tx_wr0, busy0, grant0, tx_flag0;
    logic [7:0] tx_data0;

    int         dcnt1 = 0, dcnt0 = 0;
    int         sent_a = 0, sent_b = 0;
    logic       lfn1 = 1'b0;
    logic [7:0] q1[$], q0[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(DEPTH), .CRLF(1'b1), .MASK7(1'b1)) dut (
        .eclk(clk), .ereset_n(ereset_n),
        .a_wr(a_wr), .a_data(a_data), .a_full(a_full1), .a_ovf(a_ovf1),
        .b_wr(b_wr), .b_data(b_data), .b_full(b_full1), .b_ovf(b_ovf1),
        .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_flag(tx_flag1),
        .busy(busy1), .grant(grant1)
    );

    uart_tx_arbiter #(.DEPTH(DEPTH), .CRLF(1'b0), .MASK7(1'b1)) dut0 (
        .eclk(clk), .ereset_n(ereset_n),
        .a_wr(a_wr), .a_data(a_data), .a_full(a_full0), .a_ovf(a_ovf0),
        .b_wr(b_wr), .b_data(b_data), .b_full(b_full0), .b_ovf(b_ovf0),
        .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_flag(tx_flag0),
        .busy(busy0), .grant(grant0)
    );

    // UART model: ready drops for 'drop' cycles after each write strobe.
    assign tx_flag1 = flag_en && (dcnt1 == 0);
    assign tx_flag0 = flag_en && (dcnt0 == 0);

    always @(negedge clk) begin
        if (tx_wr1) begin
            q1.push_back(tx_data1);
            dcnt1 <= drop;
            if (lfn1) begin
                lfn1 <= 1'b0;
            end else begin
                if (tx_data1[6]) sent_b <= sent_b + 1;
                else             sent_a <= sent_a + 1;
                lfn1 <= (tx_data1[6:0] == 7'h0D);
            end
        end else if (dcnt1 != 0) begin
            dcnt1 <= dcnt1 - 1;
        end
    end

    always @(negedge clk) begin
        if (tx_wr0) begin
            q0.push_back(tx_data0);
            dcnt0 <= drop;
        end else if (dcnt0 != 0) begin
            dcnt0 <= dcnt0 - 1;
        end
    end

    typedef struct packed {
        int          na;
        logic [15:0] a;
        int          nb;
        logic [15:0] b;
        int          drp;
        int          n1;
        logic [31:0] e1;
        int          n0;
        logic [31:0] e0;
        logic        g;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        ereset_n = 1'b0;
        a_wr = 1'b0;
        b_wr = 1'b0;
        repeat (n) @(negedge clk);
        ereset_n = 1'b1;
        q1.delete();
        q0.delete();
    endtask

    task automatic push_cycle(input logic wa, input logic [7:0] da, input logic wb, input logic [7:0] db);
        @(negedge clk);
        a_wr = wa;
        a_data = da;
        b_wr = wb;
        b_data = db;
        @(negedge clk);
        a_wr = 1'b0;
        b_wr = 1'b0;
    endtask

    task automatic wait_done(input int n1, input int n0, input int budget);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (q1.size() >= n1 && q0.size() >= n0 && !busy1 && !busy0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout", 32'd0, 32'd1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        vec_t       t;
        int         nmax, pa, pb, sa0, sb0;
        logic [7:0] d, e;
        logic [7:0] ma[$], mb[$];
        bit         lfx, ok;

        tbl[0] = '{na:1, a:16'h00C1, nb:0, b:16'h0000, drp:3, n1:1, e1:32'h00000041,
                   n0:1, e0:32'h00000041, g:1'b0};
        tbl[1] = '{na:2, a:16'h3231, nb:2, b:16'h6261, drp:10, n1:4, e1:32'h62326131,
                   n0:4, e0:32'h62326131, g:1'b1};
        tbl[2] = '{na:1, a:16'h008D, nb:1, b:16'h0058, drp:2, n1:3, e1:32'h00580A0D,
                   n0:2, e0:32'h0000580D, g:1'b1};
        tbl[3] = '{na:0, a:16'h0000, nb:1, b:16'h000D, drp:0, n1:2, e1:32'h00000A0D,
                   n0:1, e0:32'h0000000D, g:1'b1};
        tbl[4] = '{na:2, a:16'h4241, nb:0, b:16'h0000, drp:5, n1:2, e1:32'h00004241,
                   n0:2, e0:32'h00004241, g:1'b0};

        // Reset state
        reset_dut(3);
        chk("rst_tx_wr", 32'(tx_wr1), 32'd0);
        chk("rst_tx_data", 32'(tx_data1), 32'h00);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_a_full", 32'(a_full1), 32'd0);
        chk("rst_b_full", 32'(b_full1), 32'd0);
        chk("rst_a_ovf", 32'(a_ovf1), 32'd0);
        chk("rst_b_ovf", 32'(b_ovf1), 32'd0);
        chk("rst_grant", 32'(grant1), 32'd1);

        // Table-driven sequences, each from reset
        for (int k = 0; k < 5; k++) begin
            t = tbl[k];
            reset_dut(2);
            drop = t.drp;
            flag_en = 1'b0;
            nmax = (t.na > t.nb) ? t.na : t.nb;
            for (int i = 0; i < nmax; i++)
                push_cycle(i < t.na, t.a[8*i +: 8], i < t.nb, t.b[8*i +: 8]);
            flag_en = 1'b1;
            wait_done(t.n1, t.n0, 400);
            chk($sformatf("v%0d_count_crlf", k), q1.size(), t.n1);
            chk($sformatf("v%0d_count_nocrlf", k), q0.size(), t.n0);
            for (int i = 0; i < t.n1; i++)
                if (i < q1.size()) chk($sformatf("v%0d_byte%0d_crlf", k, i), 32'(q1[i]), 32'(t.e1[8*i +: 8]));
            for (int i = 0; i < t.n0; i++)
                if (i < q0.size()) chk($sformatf("v%0d_byte%0d_nocrlf", k, i), 32'(q0[i]), 32'(t.e0[8*i +: 8]));
            chk($sformatf("v%0d_busy", k), 32'(busy1), 32'd0);
            chk($sformatf("v%0d_grant", k), 32'(grant1), 32'(t.g));
        end

        // Overflow and backpressure on B
        reset_dut(2);
        flag_en = 1'b0;
        drop = 1;
        for (int i = 0; i < 17; i++) begin
            push_cycle(1'b0, 8'h00, 1'b1, 8'(8'h20 + i));
            if (i == 14) chk("ovf_full_at15", 32'(b_full1), 32'd0);
            if (i == 15) begin
                chk("ovf_full_at16", 32'(b_full1), 32'd1);
                chk("ovf_noovf_at16", 32'(b_ovf1), 32'd0);
            end
        end
        chk("ovf_b_ovf", 32'(b_ovf1), 32'd1);
        chk("ovf_a_ovf", 32'(a_ovf1), 32'd0);
        chk("ovf_b_full", 32'(b_full1), 32'd1);
        flag_en = 1'b1;
        wait_done(16, 16, 800);
        chk("ovf_sent", q1.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            if (i < q1.size()) chk($sformatf("ovf_byte%0d", i), 32'(q1[i]), 32'(8'h20 + i));
        chk("ovf_sticky", 32'(b_ovf1), 32'd1);

        // Reset during WAIT of the first byte
        reset_dut(2);
        flag_en = 1'b0;
        drop = 10;
        for (int i = 0; i < 3; i++) push_cycle(1'b1, 8'(8'h11 + i), 1'b0, 8'h00);
        flag_en = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (q1.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rmid_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rmid_busy_wait", 32'(busy1), 32'd1);
        ereset_n = 1'b0;
        @(negedge clk);
        ereset_n = 1'b1;
        chk("rmid_busy", 32'(busy1), 32'd0);
        chk("rmid_tx_wr", 32'(tx_wr1), 32'd0);
        chk("rmid_grant", 32'(grant1), 32'd1);
        repeat (40) @(negedge clk);
        chk("rmid_no_more_tx", q1.size(), 32'd1);
        push_cycle(1'b1, 8'h55, 1'b0, 8'h00);
        wait_done(2, 2, 100);
        chk("rmid_after_count", q1.size(), 32'd2);
        if (q1.size() >= 2) chk("rmid_after_byte", 32'(q1[1]), 32'h55);

        // Randomised traffic against a stream-level model
        reset_dut(2);
        sa0 = sent_a;
        sb0 = sent_b;
        pa = 0;
        pb = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            flag_en = ($urandom_range(0, 7) != 0);
            drop = $urandom_range(0, 4);
            a_wr = 1'b0;
            b_wr = 1'b0;
            if ($urandom_range(0, 2) == 0 && (pa - (sent_a - sa0)) < DEPTH) begin
                d = 8'($urandom_range(0, 63));
                d[7] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) d[6:0] = 7'h0D;
                a_wr = 1'b1;
                a_data = d;
                ma.push_back({1'b0, d[6:0]});
                pa++;
            end
            if ($urandom_range(0, 2) == 0 && (pb - (sent_b - sb0)) < DEPTH) begin
                d = 8'($urandom_range(0, 63));
                d[6] = 1'b1;
                d[7] = 1'($urandom_range(0, 1));
                b_wr = 1'b1;
                b_data = d;
                mb.push_back({1'b0, d[6:0]});
                pb++;
            end
        end
        @(negedge clk);
        a_wr = 1'b0;
        b_wr = 1'b0;
        flag_en = 1'b1;
        drop = 0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pa == (sent_a - sa0) && pb == (sent_b - sb0) && !busy1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rnd_drain_timeout", 32'd0, 32'd1);
        repeat (10) @(negedge clk);
        lfx = 1'b0;
        foreach (q1[i]) begin
            if (lfx) begin
                chk($sformatf("rnd_lf%0d", i), 32'(q1[i]), 32'h0A);
                lfx = 1'b0;
            end else if (q1[i][6]) begin
                if (mb.size() == 0) chk($sformatf("rnd_extra_b%0d", i), 32'd1, 32'd0);
                else begin
                    e = mb.pop_front();
                    chk($sformatf("rnd_b%0d", i), 32'(q1[i]), 32'(e));
                end
            end else begin
                if (ma.size() == 0) chk($sformatf("rnd_extra_a%0d", i), 32'd1, 32'd0);
                else begin
                    e = ma.pop_front();
                    chk($sformatf("rnd_a%0d", i), 32'(q1[i]), 32'(e));
                    lfx = (e[6:0] == 7'h0D);
                end
            end
        end
        chk("rnd_a_left", ma.size(), 32'd0);
        chk("rnd_b_left", mb.size(), 32'd0);
        chk("rnd_a_ovf", 32'(a_ovf1), 32'd0);
        chk("rnd_b_ovf", 32'(b_ovf1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
